uart_slip_rx: RTL and testbench

SLIP (RFC 1055) frame decoder that sits directly downstream of `uart_rx`. It consumes its 8-bit AXI4-Stream byte output and removes escape sequences. It then delivers decoded packets as an AXI4-Stream with `tlast` marking frame end and `tuser` flagging bad frames. A one-byte holding register lets `tlast` attach to the final data byte of each frame.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_slip_rx.sv | 136 +++++++++++++
 tb/tb_uart_slip_rx.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART/SLIP constants, used by the SLIP receive decoder and the future SLIP encoder.
package uart_pkg;

  localparam logic [7:0] SLIP_END     = 8'hC0;
  localparam logic [7:0] SLIP_ESC     = 8'hDB;
  localparam logic [7:0] SLIP_ESC_END = 8'hDC;
  localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

endpackage

// File: rtl/uart_slip_rx.sv
// SLIP frame decoder: unescapes the uart_rx byte stream into AXI4-Stream packets with tlast/tuser.
// Optional UART_SLIP_STRICT_EN: an invalid escape marks the frame bad instead of passing the byte through.
module uart_slip_rx
  import uart_pkg::*;
#(
  parameter int MAX_LEN = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] input_axi_tdata,
  input  logic       input_axi_tvalid,
  output logic       input_axi_tready,
  output logic [7:0] output_axi_tdata,
  output logic       output_axi_tvalid,
  input  logic       output_axi_tready,
  output logic       output_axi_tlast,
  output logic       output_axi_tuser,
  output logic       busy,
  output logic       frame_error
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic             pend_valid, nxt_pend_valid;
  logic [7:0]       pend_data, nxt_pend_data;
  logic             esc, nxt_esc;
  logic             err, nxt_err;
  logic [LEN_W-1:0] len, nxt_len;

  logic       out_tvalid_p1, out_tlast_p1, out_tuser_p1;
  logic [7:0] out_tdata_p1;

  logic       accept, have_d, emit, emit_last, emit_user, fe_set, close_bad;
  logic [7:0] d;

  // Accepting a byte only when the output register is free or draining keeps every emission lossless.
  assign input_axi_tready = !out_tvalid_p1 || output_axi_tready;
  assign accept           = input_axi_tvalid && input_axi_tready;

  always_comb begin
    nxt_pend_valid = pend_valid;
    nxt_pend_data  = pend_data;
    nxt_esc        = esc;
    nxt_err        = err;
    nxt_len        = len;
    emit           = 1'b0;
    emit_last      = 1'b0;
    emit_user      = 1'b0;
    fe_set         = 1'b0;
    have_d         = 1'b0;
    d              = input_axi_tdata;
    close_bad      = err || esc;
    if (accept) begin
      if (input_axi_tdata == SLIP_END) begin
        // Plain END and ESC-END abort share this path; an abort is bad through close_bad.
        emit           = pend_valid;
        emit_last      = 1'b1;
        emit_user      = close_bad;
        fe_set         = close_bad;
        nxt_pend_valid = 1'b0;
        nxt_esc        = 1'b0;
        nxt_err        = 1'b0;
        nxt_len        = '0;
      end else if (esc) begin
        nxt_esc = 1'b0;
        if (input_axi_tdata == SLIP_ESC_END) begin
          d      = SLIP_END;
          have_d = 1'b1;
        end else if (input_axi_tdata == SLIP_ESC_ESC) begin
          d      = SLIP_ESC;
          have_d = 1'b1;
        end else begin
`ifdef UART_SLIP_STRICT_EN
          nxt_err = 1'b1;
`else
          have_d = 1'b1;
`endif
        end
      end else if (input_axi_tdata == SLIP_ESC) begin
        nxt_esc = 1'b1;
      end else begin
        have_d = 1'b1;
      end

      if (have_d) begin
        if (len == LEN_MAX) begin
          nxt_err = 1'b1;
        end else begin
          emit           = pend_valid;
          nxt_pend_data  = d;
          nxt_pend_valid = 1'b1;
          nxt_len        = len + LEN_W'(1);
        end
      end
    end
  end

  // Stage p1: decoder state and registered output
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid    <= 1'b0;
      pend_data     <= 8'h00;
      esc           <= 1'b0;
      err           <= 1'b0;
      len           <= '0;
      out_tvalid_p1 <= 1'b0;
      out_tdata_p1  <= 8'h00;
      out_tlast_p1  <= 1'b0;
      out_tuser_p1  <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      pend_valid  <= nxt_pend_valid;
      pend_data   <= nxt_pend_data;
      esc         <= nxt_esc;
      err         <= nxt_err;
      len         <= nxt_len;
      frame_error <= fe_set;
      if (emit) begin
        out_tvalid_p1 <= 1'b1;
        out_tdata_p1  <= pend_data;
        out_tlast_p1  <= emit_last;
        out_tuser_p1  <= emit_user;
      end else if (output_axi_tready) begin
        out_tvalid_p1 <= 1'b0;
      end
    end
  end

  assign output_axi_tvalid = out_tvalid_p1;
  assign output_axi_tdata  = out_tdata_p1;
  assign output_axi_tlast  = out_tlast_p1;
  assign output_axi_tuser  = out_tuser_p1;
  assign busy              = pend_valid || esc || err || (len != '0);

endmodule

// File: tb/tb_uart_slip_rx.sv
// Bench for uart_slip_rx: frame-level reference decoder, per-cycle compare process, directed and random frames.
module tb_uart_slip_rx;

  localparam int MAX_LEN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_tdata = 8'h00;
  logic       in_tvalid = 1'b0;
  logic       in_tready;
  logic [7:0] out_tdata;
  logic       out_tvalid;
  logic       out_tready = 1'b1;
  logic       out_tlast;
  logic       out_tuser;
  logic       busy;
  logic       frame_error;

  int checks = 0;
  int errors = 0;

  // Reference model state: decoded bytes of the open frame and expected entries {last,user,data}.
  logic [7:0] cur[$];
  bit         m_esc = 1'b0;
  bit         m_bad = 1'b0;
  bit         fe_exp = 1'b0;
  logic [9:0] exp_q[$];
  logic [9:0] obs_buf[$];
  logic [9:0] log_q[$];
  logic [9:0] lit[$];
  logic [7:0] stim[$];
  int         fe_count = 0;
  bit         rand_rdy = 1'b0;
  bit         prev_stall = 1'b0;
  logic [10:0] prev_out = '0;

  uart_slip_rx #(.MAX_LEN(MAX_LEN)) dut (
    .clk               (clk),
    .rst               (rst),
    .input_axi_tdata   (in_tdata),
    .input_axi_tvalid  (in_tvalid),
    .input_axi_tready  (in_tready),
    .output_axi_tdata  (out_tdata),
    .output_axi_tvalid (out_tvalid),
    .output_axi_tready (out_tready),
    .output_axi_tlast  (out_tlast),
    .output_axi_tuser  (out_tuser),
    .busy              (busy),
    .frame_error       (frame_error)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_add(input logic [7:0] d);
    if (cur.size() == MAX_LEN) m_bad = 1'b1;
    else cur.push_back(d);
  endtask

  task automatic model_accept(input logic [7:0] b);
    bit bad;
    if (b == 8'hC0) begin
      bad = m_bad || m_esc;
      for (int i = 0; i < cur.size(); i++) begin
        if (i == cur.size() - 1) exp_q.push_back({1'b1, bad, cur[i]});
        else exp_q.push_back({2'b00, cur[i]});
      end
      fe_exp = bad;
      cur.delete();
      m_esc = 1'b0;
      m_bad = 1'b0;
    end else if (m_esc) begin
      m_esc = 1'b0;
      if (b == 8'hDC) model_add(8'hC0);
      else if (b == 8'hDD) model_add(8'hDB);
      else begin
`ifdef UART_SLIP_STRICT_EN
        m_bad = 1'b1;
`else
        model_add(b);
`endif
      end
    end else if (b == 8'hDB) begin
      m_esc = 1'b1;
    end else begin
      model_add(b);
    end
  endtask

  initial forever begin
    @(negedge clk);
    out_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Compare process: samples 2 time units after the falling edge, every cycle out of reset.
  initial forever begin
    logic [9:0] e;
    @(negedge clk);
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check("frame_error", frame_error, fe_exp);
      fe_exp = 1'b0;
      if (frame_error) fe_count++;
      check("busy", busy, (cur.size() > 0) || m_esc || m_bad);
      if (prev_stall) check("hold_stable", {out_tvalid, out_tlast, out_tuser, out_tdata}, prev_out);
      if (out_tvalid && out_tready) begin
        e = {out_tlast, out_tuser, out_tdata};
        log_q.push_back(e);
        obs_buf.push_back(e);
        if (out_tlast) begin
          foreach (obs_buf[i]) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL frame_byte: actual=%0h required=none", obs_buf[i]);
            end else begin
              check("frame_byte", obs_buf[i], exp_q.pop_front());
            end
          end
          obs_buf.delete();
        end
      end
      prev_stall = out_tvalid && !out_tready;
      prev_out   = {out_tvalid, out_tlast, out_tuser, out_tdata};
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clk);
    #1;
    in_tdata  = b;
    in_tvalid = 1'b1;
    #2;
    n = 0;
    while (!in_tready && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (!in_tready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: actual=stalled required=accepted byte %0h", b);
    end else begin
      model_accept(b);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_tvalid = 1'b0;
  endtask

  task automatic send_list();
    foreach (stim[i]) send(stim[i]);
    idle();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((out_tvalid || exp_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: actual=%0d pending required=0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_log();
    check("log_len", log_q.size(), lit.size());
    for (int i = 0; i < log_q.size() && i < lit.size(); i++)
      check("log_entry", log_q[i], lit[i]);
  endtask

  task automatic start_case();
    log_q.delete();
    fe_count = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst       = 1'b1;
    in_tvalid = 1'b0;
    cur.delete();
    m_esc  = 1'b0;
    m_bad  = 1'b0;
    fe_exp = 1'b0;
    obs_buf.delete();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int         n;
    int         r;

    repeat (3) @(negedge clk);
    #2;
    check("rst_tvalid", out_tvalid, 1'b0);
    check("rst_tdata", out_tdata, 8'h00);
    check("rst_tlast", out_tlast, 1'b0);
    check("rst_tuser", out_tuser, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_error", frame_error, 1'b0);
    check("rst_in_tready", in_tready, 1'b1);
    #1;
    rst = 1'b0;

    // Basic frame, with the last byte one cycle after END is accepted
    start_case();
    send(8'hC0); send(8'h01); send(8'h02); send(8'h03); send(8'hC0);
    idle();
    @(negedge clk);
    #2;
    check("last_latency", {out_tvalid, out_tlast, out_tuser, out_tdata}, {3'b110, 8'h03});
    drain();
    lit = '{10'h001, 10'h002, 10'h203};
    check_log();
    check("basic_fe_count", fe_count, 0);

    start_case();
    stim = '{8'h10, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'hC0};
    send_list(); drain();
    lit = '{10'h010, 10'h0C0, 10'h2DB};
    check_log();
    check("escape_fe_count", fe_count, 0);

    start_case();
    stim = '{8'hC0, 8'hC0, 8'hC0};
    send_list(); drain();
    lit.delete();
    check_log();
    check("empty_fe_count", fe_count, 0);
    check("empty_busy", busy, 1'b0);

    start_case();
    stim = '{8'h05, 8'hDB, 8'h41, 8'hC0};
    send_list(); drain();
`ifdef UART_SLIP_STRICT_EN
    lit = '{10'h305};
    check_log();
    check("badesc_fe_count", fe_count, 1);
`else
    lit = '{10'h005, 10'h241};
    check_log();
    check("badesc_fe_count", fe_count, 0);
`endif

    start_case();
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hC0};
    send_list(); drain();
    lit = '{10'h001, 10'h002, 10'h003, 10'h304};
    check_log();
    check("overlen_fe_count", fe_count, 1);

    start_case();
    stim = '{8'h07, 8'hDB, 8'hC0};
    send_list(); drain();
    lit = '{10'h307};
    check_log();
    check("abort_fe_count", fe_count, 1);

    // Random frames under random backpressure, with one reset cutting a frame
    rand_rdy = 1'b1;
    for (int f = 0; f < 100; f++) begin
      if (f == 50) begin
        send(8'h01);
        send(8'h02);
        idle();
        do_reset();
        @(negedge clk);
        #2;
        check("midrst_tvalid", out_tvalid, 1'b0);
        check("midrst_busy", busy, 1'b0);
      end
      n = $urandom_range(0, 7);
      for (int j = 0; j < n; j++) begin
        r = $urandom_range(0, 9);
        case (r)
          0:       b = 8'hC0;
          1:       b = 8'hDB;
          2:       b = 8'hDC;
          3:       b = 8'hDD;
          default: b = 8'($urandom_range(0, 255));
        endcase
        send(b);
      end
      send(8'hC0);
    end
    idle();
    drain();
    rand_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check("final_exp_empty", exp_q.size(), 0);
    check("final_obs_empty", obs_buf.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
